// File: rtl/point_distance_sq.sv
// Squared Euclidean distance between two DIM-axis signed points, with an
// inclusive collision flag against an unsigned threshold. One shared
// subtract / square-accumulate path walks the axes; stb/ack handshakes on
// both sides.
module point_distance_sq #(
   parameter  int WIDTH = 16,
   parameter  int DIM   = 3,
   localparam int SUM_W = 2*WIDTH + $clog2(DIM)
) (
   input  logic                   CLK,
   input  logic                   rst_n,
   input  logic [DIM*WIDTH-1:0]   input_a,
   input  logic [DIM*WIDTH-1:0]   input_b,
   input  logic [SUM_W-1:0]       input_threshold,
   input  logic                   input_stb,
   output logic                   input_ack,
   output logic [SUM_W-1:0]       output_z,
   output logic                   output_collide,
   output logic                   output_z_stb,
   input  logic                   output_z_ack
);

   localparam int AXW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [AXW-1:0] LAST_AXIS = AXW'(DIM - 1);

   typedef enum logic [1:0] {IDLE, DIFF, SQ, PUT} state_t;

   state_t                 state;
   logic [DIM*WIDTH-1:0]   a_r;
   logic [DIM*WIDTH-1:0]   b_r;
   logic [SUM_W-1:0]       thr_r;
   logic [AXW-1:0]         axis;
   logic [SUM_W-1:0]       acc;
   logic signed [WIDTH:0]  diff;

   logic [WIDTH-1:0]         a_ax;
   logic [WIDTH-1:0]         b_ax;
   logic signed [WIDTH:0]    a_ext;
   logic signed [WIDTH:0]    b_ext;
   logic signed [2*WIDTH+1:0] sq_full;
   logic [SUM_W-1:0]         sum;

   // Current-axis operand selection, sign extension, square and running sum
   always_comb begin
      a_ax    = a_r[int'(axis)*WIDTH +: WIDTH];
      b_ax    = b_r[int'(axis)*WIDTH +: WIDTH];
      a_ext   = signed'({a_ax[WIDTH-1], a_ax});
      b_ext   = signed'({b_ax[WIDTH-1], b_ax});
      sq_full = diff * diff;
      // square is non-negative and below 2**(2*WIDTH); resizing to SUM_W is lossless
      sum     = acc + SUM_W'($unsigned(sq_full));
   end

   // Control FSM: accept, per-axis DIFF/SQ iteration, hold result until taken
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         input_ack      <= 1'b0;
         output_z_stb   <= 1'b0;
         output_z       <= '0;
         output_collide <= 1'b0;
         axis           <= '0;
         acc            <= '0;
         diff           <= '0;
         a_r            <= '0;
         b_r            <= '0;
         thr_r          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!input_ack) begin
                  input_ack <= 1'b1;
               end else if (input_stb) begin
                  a_r       <= input_a;
                  b_r       <= input_b;
                  thr_r     <= input_threshold;
                  axis      <= '0;
                  acc       <= '0;
                  input_ack <= 1'b0;
                  state     <= DIFF;
               end
            end
            DIFF: begin
               diff  <= a_ext - b_ext;
               state <= SQ;
            end
            SQ: begin
               acc <= sum;
               if (axis == LAST_AXIS) begin
                  output_z       <= sum;
                  output_collide <= (sum <= thr_r);
                  output_z_stb   <= 1'b1;
                  state          <= PUT;
               end else begin
                  axis  <= axis + AXW'(1);
                  state <= DIFF;
               end
            end
            PUT: begin
               if (output_z_ack) begin
                  output_z_stb <= 1'b0;
                  input_ack    <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_point_distance_sq.sv
// Self-checking bench for point_distance_sq: a 16-bit 3-axis instance driven
// through a scoreboard, plus an 8-bit single-axis instance.
module tb_point_distance_sq;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;

   // 16-bit, 3-axis instance
   logic [47:0] input_a = '0;
   logic [47:0] input_b = '0;
   logic [33:0] input_threshold = '0;
   logic        input_stb = 1'b0;
   logic        input_ack;
   logic [33:0] output_z;
   logic        output_collide;
   logic        output_z_stb;
   logic        output_z_ack = 1'b1;

   // 8-bit, 1-axis instance
   logic [7:0]  a2 = '0;
   logic [7:0]  b2 = '0;
   logic [15:0] thr2 = '0;
   logic        stb2 = 1'b0;
   logic        ack2;
   logic [15:0] z2;
   logic        col2;
   logic        zstb2;
   logic        zack2 = 1'b1;

   point_distance_sq #(.WIDTH(16), .DIM(3)) dut (
      .CLK(CLK), .rst_n(rst_n),
      .input_a(input_a), .input_b(input_b), .input_threshold(input_threshold),
      .input_stb(input_stb), .input_ack(input_ack),
      .output_z(output_z), .output_collide(output_collide),
      .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
   );

   point_distance_sq #(.WIDTH(8), .DIM(1)) dut1 (
      .CLK(CLK), .rst_n(rst_n),
      .input_a(a2), .input_b(b2), .input_threshold(thr2),
      .input_stb(stb2), .input_ack(ack2),
      .output_z(z2), .output_collide(col2),
      .output_z_stb(zstb2), .output_z_ack(zack2)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [33:0] z;
      logic        c;
   } exp_t;

   exp_t sb[$];
   int   acc_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   n_hs = 0;
   logic prev_stb = 1'b0;
   logic overlap = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] pt(input int x, input int y, input int z);
      return {16'(z), 16'(y), 16'(x)};
   endfunction

   function automatic longint model(input logic [47:0] a, input logic [47:0] b);
      longint s = 0;
      for (int k = 0; k < 3; k++) begin
         longint d = longint'($signed(a[k*16 +: 16])) - longint'($signed(b[k*16 +: 16]));
         s += d * d;
      end
      return s;
   endfunction

   always @(posedge CLK) cyc++;

   // Monitor: accepts, latency, result pop/compare, ack/stb exclusivity
   always @(negedge CLK) begin
      if (rst_n) begin
         if (input_ack && output_z_stb) overlap = 1'b1;
         if (input_stb && input_ack) begin
            last_acc = cyc + 1;
            acc_q.push_back(cyc + 1);
         end
         if (output_z_stb && !prev_stb) check("latency", 64'(cyc - last_acc), 64'd6);
         if (output_z_stb && output_z_ack) begin
            n_hs++;
            check("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("result_z", 64'(output_z), 64'(e.z));
               check("result_collide", 64'(output_collide), 64'(e.c));
            end
         end
      end
      prev_stb = output_z_stb;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 60 && !input_ack; i++) tick();
      if (!input_ack) check("wait_ack", 64'(input_ack), 64'd1);
   endtask

   task automatic send(input logic [47:0] a, input logic [47:0] b, input logic [33:0] thr);
      exp_t   e;
      longint m;
      wait_ack();
      m   = model(a, b);
      e.z = 34'(m);
      e.c = (m <= longint'(thr));
      input_a = a;
      input_b = b;
      input_threshold = thr;
      input_stb = 1'b1;
      sb.push_back(e);
      tick();
      input_stb = 1'b0;
      // scramble inputs after accept; the result in flight must not see this
      input_a = ~a;
      input_b = a;
      input_threshold = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (sb.size() != 0 || output_z_stb); i++) tick();
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      logic [47:0] ra, rb;

      // reset state
      tick(); tick();
      check("rst_input_ack", 64'(input_ack), 64'd0);
      check("rst_z_stb", 64'(output_z_stb), 64'd0);
      check("rst_z", 64'(output_z), 64'd0);
      check("rst_collide", 64'(output_collide), 64'd0);
      rst_n = 1'b1;
      check("ack_before_edge", 64'(input_ack), 64'd0);
      tick();
      check("ack_after_release", 64'(input_ack), 64'd1);

      // basic and threshold boundary
      send(pt(3, 4, 0), pt(0, 0, 0), 34'd25);
      send(pt(3, 4, 0), pt(0, 0, 0), 34'd24);
      // extremes and coincident points
      send(pt(32767, 32767, 32767), pt(-32768, -32768, -32768), 34'd0);
      send(pt(-5, 7, -1), pt(-5, 7, -1), 34'd0);
      send(pt(1, 0, 0), pt(0, 0, 0), 34'd0);
      for (int i = 0; i < 3; i++) begin
         ra = {16'($urandom), 16'($urandom), 16'($urandom)};
         rb = {16'($urandom), 16'($urandom), 16'($urandom)};
         send(ra, rb, 34'($urandom) << 2);
      end
      drain();
      check("extreme_const", 64'(model(pt(32767, 32767, 32767), pt(-32768, -32768, -32768))),
            64'd12884508675);

      // backpressure
      output_z_ack = 1'b0;
      send(pt(1, 2, 3), pt(4, 6, 3), 34'd100);
      for (int i = 0; i < 20 && !output_z_stb; i++) tick();
      check("bp_stb_rise", 64'(output_z_stb), 64'd1);
      hs0 = n_hs;
      for (int i = 0; i < 5; i++) begin
         input_a = {16'($urandom), 16'($urandom), 16'($urandom)};
         input_stb = (i % 2 == 1);
         tick();
         check("bp_stb_held", 64'(output_z_stb), 64'd1);
         check("bp_z_held", 64'(output_z), 64'd25);
         check("bp_collide_held", 64'(output_collide), 64'd1);
         check("bp_input_ack", 64'(input_ack), 64'd0);
      end
      input_stb = 1'b0;
      output_z_ack = 1'b1;
      tick();
      check("bp_one_hs", 64'(n_hs - hs0), 64'd1);
      check("bp_stb_low", 64'(output_z_stb), 64'd0);
      check("bp_ack_back", 64'(input_ack), 64'd1);
      check("idle_z_kept", 64'(output_z), 64'd25);
      tick(); tick(); tick();
      check("bp_no_extra_hs", 64'(n_hs - hs0), 64'd1);
      check("bp_sb_empty", 64'(sb.size()), 64'd0);

      // back-to-back with stb and ack held high
      acc_q.delete();
      input_stb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_t   e;
         longint m;
         wait_ack();
         input_a = pt(10 * i + 1, -3 * i, 7);
         input_b = pt(-i, 2 * i, -100 + i);
         input_threshold = 34'd10500;
         m   = model(input_a, input_b);
         e.z = 34'(m);
         e.c = (m <= 10500);
         sb.push_back(e);
         tick();
      end
      input_stb = 1'b0;
      drain();
      check("b2b_accepts", 64'(acc_q.size()), 64'd4);
      if (acc_q.size() == 4)
         for (int i = 1; i < 4; i++)
            check("b2b_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'd8);

      // reset while in SQ at axis 1
      wait_ack();
      input_a = pt(10, 20, 30);
      input_b = pt(0, 0, 0);
      input_threshold = '1;
      input_stb = 1'b1;
      tick();
      input_stb = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_stb", 64'(output_z_stb), 64'd0);
      check("mid_rst_z", 64'(output_z), 64'd0);
      check("mid_rst_collide", 64'(output_collide), 64'd0);
      check("mid_rst_ack", 64'(input_ack), 64'd0);
      tick();
      rst_n = 1'b1;
      check("mid_rel_ack0", 64'(input_ack), 64'd0);
      tick();
      check("mid_rel_ack1", 64'(input_ack), 64'd1);
      send(pt(-2, 2, 1), pt(1, -2, 1), 34'd25);
      drain();
      check("ack_stb_overlap", 64'(overlap), 64'd0);

      // single-axis 8-bit instance
      for (int t = 0; t < 2; t++) begin
         int n;
         for (int i = 0; i < 20 && !ack2; i++) tick();
         check("d1_ack", 64'(ack2), 64'd1);
         a2 = 8'h80;
         b2 = 8'd127;
         thr2 = (t == 0) ? 16'd65025 : 16'd65024;
         stb2 = 1'b1;
         tick();
         stb2 = 1'b0;
         n = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (zstb2) break;
         end
         check("d1_latency", 64'(n), 64'd2);
         check("d1_z", 64'(z2), 64'd65025);
         check("d1_collide", 64'(col2), (t == 0) ? 64'd1 : 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
